// File: rtl/risk_rate_limiter_mc.sv
// Multi-symbol token-bucket rate limiter with a registered valid/ready output stage.
// Define RISK_RATE_STATS_EN to implement the 64-bit order counters; otherwise stat_* read 0.
module risk_rate_limiter_mc #(
  parameter int unsigned NUM_SYMBOLS  = 8,
  parameter int unsigned TOKEN_WIDTH  = 32,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned DATA_WIDTH   = 64,
  localparam int unsigned SymW        = $clog2(NUM_SYMBOLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TOKEN_WIDTH-1:0]  cfg_max_tokens,
  input  logic [TOKEN_WIDTH-1:0]  cfg_refill_rate,
  input  logic [PERIOD_WIDTH-1:0] cfg_refill_period,
  input  logic                    cfg_enabled,
  input  logic                    cmd_refill_all,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [31:0]             in_symbol_id,
  input  logic [7:0]              in_cost,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [SymW-1:0]         out_bucket,
  output logic                    out_rejected,
  output logic [7:0]              out_reject_reason,
  input  logic [SymW-1:0]         status_sel,
  output logic [TOKEN_WIDTH-1:0]  status_tokens,
  output logic [63:0]             stat_total,
  output logic [63:0]             stat_passed,
  output logic [63:0]             stat_rejected
);

  logic [TOKEN_WIDTH-1:0]  buckets_q [NUM_SYMBOLS];
  logic [TOKEN_WIDTH-1:0]  buckets_d [NUM_SYMBOLS];
  logic [TOKEN_WIDTH-1:0]  bucket_after [NUM_SYMBOLS];
  logic [TOKEN_WIDTH:0]    bucket_sum [NUM_SYMBOLS];
  logic [PERIOD_WIDTH-1:0] period_cnt_q;

  logic                    out_valid_q, out_rejected_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [SymW-1:0]         out_bucket_q;
  logic [7:0]              out_reason_q;

  logic                    accept, tick, reject, debit;
  logic [SymW-1:0]         sel;
  logic [TOKEN_WIDTH-1:0]  cost_ext, t_cur;
  logic                    unused_symbol_hi;

  assign unused_symbol_hi = ^in_symbol_id[31:SymW];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign tick     = (period_cnt_q == cfg_refill_period);
  assign sel      = in_symbol_id[SymW-1:0];
  assign cost_ext = TOKEN_WIDTH'(in_cost);
  assign t_cur    = buckets_q[sel];
  assign reject   = cfg_enabled && (t_cur < cost_ext);
  assign debit    = accept && cfg_enabled && !reject;

  // Debit first, then refill, then saturate; the extra sum bit keeps the add from wrapping.
  always_comb begin
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      bucket_after[i] = buckets_q[i];
      if (debit && (sel == SymW'(i))) bucket_after[i] = buckets_q[i] - cost_ext;
      bucket_sum[i] = {1'b0, bucket_after[i]} + {1'b0, cfg_refill_rate};
      if (cmd_refill_all) begin
        buckets_d[i] = cfg_max_tokens;
      end else if (tick) begin
        buckets_d[i] = (bucket_sum[i] > {1'b0, cfg_max_tokens}) ? cfg_max_tokens
                                                                : bucket_sum[i][TOKEN_WIDTH-1:0];
      end else begin
        buckets_d[i] = bucket_after[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYMBOLS; i++) buckets_q[i] <= cfg_max_tokens;
      period_cnt_q <= '0;
    end else begin
      buckets_q    <= buckets_d;
      period_cnt_q <= tick ? '0 : period_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_bucket_q   <= '0;
      out_rejected_q <= 1'b0;
      out_reason_q   <= 8'h00;
    end else if (accept) begin
      out_valid_q    <= 1'b1;
      out_data_q     <= in_data;
      out_bucket_q   <= sel;
      out_rejected_q <= reject;
      out_reason_q   <= reject ? 8'h01 : 8'h00;
    end else if (out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_bucket        = out_bucket_q;
  assign out_rejected      = out_rejected_q;
  assign out_reject_reason = out_reason_q;
  assign status_tokens     = buckets_q[status_sel];

`ifdef RISK_RATE_STATS_EN
  logic [63:0] stat_total_q, stat_passed_q, stat_rejected_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q    <= '0;
      stat_passed_q   <= '0;
      stat_rejected_q <= '0;
    end else if (accept) begin
      if (stat_total_q != '1) stat_total_q <= stat_total_q + 64'd1;
      if (reject && stat_rejected_q != '1) stat_rejected_q <= stat_rejected_q + 64'd1;
      if (!reject && stat_passed_q != '1) stat_passed_q <= stat_passed_q + 64'd1;
    end
  end

  assign stat_total    = stat_total_q;
  assign stat_passed   = stat_passed_q;
  assign stat_rejected = stat_rejected_q;
`else
  assign stat_total    = '0;
  assign stat_passed   = '0;
  assign stat_rejected = '0;
`endif

endmodule

// File: tb/tb_risk_rate_limiter_mc.sv
// Directed self-checking bench for risk_rate_limiter_mc (default parameters).
module tb_risk_rate_limiter_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_max_tokens, cfg_refill_rate;
  logic [15:0] cfg_refill_period;
  logic        cfg_enabled, cmd_refill_all;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic [31:0] in_symbol_id;
  logic [7:0]  in_cost;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_bucket;
  logic        out_rejected;
  logic [7:0]  out_reject_reason;
  logic [2:0]  status_sel;
  logic [31:0] status_tokens;
  logic [63:0] stat_total, stat_passed, stat_rejected;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  risk_rate_limiter_mc dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_max_tokens    (cfg_max_tokens),
    .cfg_refill_rate   (cfg_refill_rate),
    .cfg_refill_period (cfg_refill_period),
    .cfg_enabled       (cfg_enabled),
    .cmd_refill_all    (cmd_refill_all),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_symbol_id      (in_symbol_id),
    .in_cost           (in_cost),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_bucket        (out_bucket),
    .out_rejected      (out_rejected),
    .out_reject_reason (out_reject_reason),
    .status_sel        (status_sel),
    .status_tokens     (status_tokens),
    .stat_total        (stat_total),
    .stat_passed       (stat_passed),
    .stat_rejected     (stat_rejected)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] s, input logic [31:0] exp, input string tag);
    status_sel = s;
    #1;
    check_eq(tag, {32'd0, status_tokens}, {32'd0, exp});
  endtask

  task automatic do_reset(input logic [31:0] mx, input logic [31:0] rate, input logic [15:0] per);
    cfg_max_tokens    = mx;
    cfg_refill_rate   = rate;
    cfg_refill_period = per;
    cfg_enabled       = 1'b1;
    cmd_refill_all    = 1'b0;
    in_valid          = 1'b0;
    out_ready         = 1'b1;
    rst               = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic order(input logic [31:0] sym, input logic [7:0] cost, input logic [63:0] data);
    in_valid     = 1'b1;
    in_symbol_id = sym;
    in_cost      = cost;
    in_data      = data;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] bkt, input logic rej,
                            input logic [63:0] data);
    check_eq({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, ".bucket"}, {61'd0, out_bucket}, {61'd0, bkt});
    check_eq({tag, ".rejected"}, {63'd0, out_rejected}, {63'd0, rej});
    check_eq({tag, ".reason"}, {56'd0, out_reject_reason}, rej ? 64'd1 : 64'd0);
    check_eq({tag, ".data"}, out_data, data);
  endtask

  logic [31:0] e_sym  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2};
  logic [7:0]  e_cost [10] = '{1, 1, 1, 1, 1, 2, 2, 2, 0, 5};
  logic        e_rej  [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    in_data      = '0;
    in_symbol_id = '0;
    in_cost      = '0;
    status_sel   = '0;

    // Reset state and drain of a single bucket.
    do_reset(32'd4, 32'd1, 16'd9);
    check_eq("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst.out_rejected", {63'd0, out_rejected}, 64'd0);
    check_eq("rst.reason", {56'd0, out_reject_reason}, 64'd0);
    check_eq("rst.out_data", out_data, 64'd0);
    check_eq("rst.out_bucket", {61'd0, out_bucket}, 64'd0);
    check_eq("rst.in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst.stat_total", stat_total, 64'd0);
    peek(3'd3, 32'd4, "rst.bucket3");
    for (int i = 0; i < 6; i++) begin
      order(32'd3, 8'd1, 64'd100 + 64'(i));
      expect_out($sformatf("drain%0d", i), 3'd3, (i >= 4), 64'd100 + 64'(i));
    end
    peek(3'd3, 32'd0, "drain.bucket3");
    order(32'h0000_0105, 8'd1, 64'd200);
    expect_out("iso", 3'd5, 1'b0, 64'd200);
    peek(3'd5, 32'd3, "iso.bucket5");
    peek(3'd3, 32'd0, "iso.bucket3");

    // Refill ticks every 4 cycles, saturating at max.
    do_reset(32'd4, 32'd2, 16'd3);
    order(32'd0, 8'd4, 64'd1);
    peek(3'd0, 32'd0, "refill.empty");
    step();
    step();
    peek(3'd0, 32'd0, "refill.pretick");
    step();
    peek(3'd0, 32'd2, "refill.tick1");
    repeat (4) step();
    peek(3'd0, 32'd4, "refill.tick2");
    repeat (4) step();
    peek(3'd0, 32'd4, "refill.sat");
    peek(3'd1, 32'd4, "refill.other");

    // Debit and tick on the same edge, then output stall.
    do_reset(32'd8, 32'd10, 16'd3);
    order(32'd2, 8'd4, 64'd10);
    expect_out("sim.first", 3'd2, 1'b0, 64'd10);
    peek(3'd2, 32'd4, "sim.pre");
    step();
    step();
    order(32'd2, 8'd3, 64'd11);
    expect_out("sim.tick", 3'd2, 1'b0, 64'd11);
    peek(3'd2, 32'd8, "sim.debit_then_refill");
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    in_symbol_id = 32'd2;
    in_cost      = 8'd1;
    in_data      = 64'd99;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("hold%0d.valid", k), {63'd0, out_valid}, 64'd1);
      check_eq($sformatf("hold%0d.data", k), out_data, 64'd11);
      check_eq($sformatf("hold%0d.in_ready", k), {63'd0, in_ready}, 64'd0);
      peek(3'd2, 32'd8, $sformatf("hold%0d.bucket", k));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("hold.drain", {63'd0, out_valid}, 64'd0);

    // Refill-all command and disabled limiter.
    do_reset(32'd4, 32'd0, 16'd0);
    order(32'd1, 8'd3, 64'd20);
    peek(3'd1, 32'd1, "cmd.pre");
    cmd_refill_all = 1'b1;
    order(32'd1, 8'd2, 64'd21);
    cmd_refill_all = 1'b0;
    expect_out("cmd", 3'd1, 1'b1, 64'd21);
    peek(3'd1, 32'd4, "cmd.bucket");
    cfg_enabled = 1'b0;
    order(32'd1, 8'd255, 64'd22);
    expect_out("dis", 3'd1, 1'b0, 64'd22);
    peek(3'd1, 32'd4, "dis.bucket");
    cfg_enabled = 1'b1;

    // Counters, then reset with an order on the output.
    do_reset(32'd4, 32'd0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      order(e_sym[i], e_cost[i], 64'd300 + 64'(i));
      expect_out($sformatf("st%0d", i), e_sym[i][2:0], e_rej[i], 64'd300 + 64'(i));
    end
`ifdef RISK_RATE_STATS_EN
    check_eq("stat_total", stat_total, 64'd10);
    check_eq("stat_passed", stat_passed, 64'd7);
    check_eq("stat_rejected", stat_rejected, 64'd3);
`else
    check_eq("stat_total", stat_total, 64'd0);
    check_eq("stat_passed", stat_passed, 64'd0);
    check_eq("stat_rejected", stat_rejected, 64'd0);
`endif
    check_eq("prerst.valid", {63'd0, out_valid}, 64'd1);
    cfg_max_tokens = 32'd6;
    rst            = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst.valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst.data", out_data, 64'd0);
    check_eq("midrst.stat_total", stat_total, 64'd0);
    peek(3'd0, 32'd6, "midrst.bucket0");
    peek(3'd7, 32'd6, "midrst.bucket7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
